// File: rtl/frame_scanner.sv
// rtl/frame_scanner.sv - frame-buffer scan-out engine: raster walk, cell addressing, 2/4/8 bpp unpack
// Optional FRAME_SCANNER_BORDER_EN: out-of-raster pixels take border_index instead of 8'h00.
module frame_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [4:0] scroll_x,
  input  logic [4:0] scroll_y,
  input  logic [7:0] border_index,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic       pixel_req,
  output logic [8:0] fb_col,
  output logic [7:0] fb_row,
  input  logic [7:0] fb_data,
  output logic [7:0] pixel_index,
  output logic       pixel_valid
);
  localparam logic [9:0] X_END = 10'd640;
  localparam logic [8:0] Y_END = 9'd480;
  localparam logic [4:0] SCROLL_MAX = 5'd16;

  logic [9:0] r_x;
  logic [8:0] r_y;
  logic [1:0] r_mode;
  logic [4:0] r_scroll_x;
  logic [4:0] r_scroll_y;

  logic       r_req_valid;
  logic [1:0] r_req_mode;
  logic       r_req_sx;
  logic       r_req_sy;
  logic       r_req_oob;
  logic [7:0] r_req_border;

  logic [9:0] w_x;
  logic [8:0] w_y;
  logic [1:0] w_mode;
  logic [4:0] w_scroll_x;
  logic [4:0] w_scroll_y;
  logic [4:0] w_clamp_x;
  logic [4:0] w_clamp_y;
  logic       w_oob;
  logic [7:0] w_border;
  logic [2:0] w_field_base;
  logic [1:0] w_field;
  logic [7:0] w_index;

`ifdef FRAME_SCANNER_BORDER_EN
  assign w_border = border_index;
`else
  // border_index is deliberately ignored in this build
  assign w_border = border_index & 8'h00;
`endif

  assign w_clamp_x = (scroll_x > SCROLL_MAX) ? SCROLL_MAX : scroll_x;
  assign w_clamp_y = (scroll_y > SCROLL_MAX) ? SCROLL_MAX : scroll_y;

  // Raster position and frame settings as seen by a request in this cycle
  always_comb begin
    w_x        = r_x;
    w_y        = r_y;
    w_mode     = r_mode;
    w_scroll_x = r_scroll_x;
    w_scroll_y = r_scroll_y;
    if (frame_start) begin
      w_x        = 10'd0;
      w_y        = 9'd0;
      w_mode     = mode;
      w_scroll_x = w_clamp_x;
      w_scroll_y = w_clamp_y;
    end else if (line_start) begin
      w_x = 10'd0;
      if (r_y != Y_END) begin
        w_y = r_y + 9'd1;
      end
    end
  end

  assign w_oob = (w_x == X_END) || (w_y == Y_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x          <= 10'd0;
      r_y          <= 9'd0;
      r_mode       <= 2'd3;
      r_scroll_x   <= 5'd0;
      r_scroll_y   <= 5'd0;
      r_req_valid  <= 1'b0;
      r_req_mode   <= 2'd3;
      r_req_sx     <= 1'b0;
      r_req_sy     <= 1'b0;
      r_req_oob    <= 1'b0;
      r_req_border <= 8'h00;
      fb_col       <= 9'd0;
      fb_row       <= 8'd0;
      pixel_index  <= 8'h00;
      pixel_valid  <= 1'b0;
    end else begin
      r_x         <= w_x;
      r_y         <= w_y;
      r_mode      <= w_mode;
      r_scroll_x  <= w_scroll_x;
      r_scroll_y  <= w_scroll_y;
      r_req_valid <= pixel_req;
      if (pixel_req) begin
        r_x          <= (w_x == X_END) ? X_END : w_x + 10'd1;
        r_req_mode   <= w_mode;
        r_req_sx     <= w_x[0];
        r_req_sy     <= w_y[0];
        r_req_oob    <= w_oob;
        r_req_border <= w_border;
        // Address is left untouched for border pixels; nothing reads it
        if (!w_oob) begin
          fb_col <= w_x[9:1] + {4'd0, w_scroll_x};
          fb_row <= w_y[8:1] + {3'd0, w_scroll_y};
        end
      end
      pixel_valid <= r_req_valid;
      if (r_req_valid) begin
        pixel_index <= w_index;
      end
    end
  end

  assign w_field_base = {r_req_sy, r_req_sx, 1'b0};
  assign w_field      = fb_data[w_field_base +: 2];

  always_comb begin
    w_index = fb_data;
    case (r_req_mode)
      2'd0:    w_index = {6'd0, w_field};
      2'd1:    w_index = {4'd0, r_req_sy ? fb_data[7:4] : fb_data[3:0]};
      2'd2:    w_index = {4'd0, r_req_sx ? fb_data[7:4] : fb_data[3:0]};
      default: w_index = fb_data;
    endcase
    if (r_req_oob) begin
      w_index = r_req_border;
    end
  end

endmodule
